bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  Parametrised N-master bus arbiter; successor of the fixed two-master approval_request/approval_grant scheme.
//  Fair round-robin grant; ownership held for a whole burst by counting bus beats (valid&ready), then released.
//  Sits between the master ports and the shared address/data mux; grant_id drives the master-side mux select.
// PARAMETERS
//  N_MASTERS       2     number of requesting masters (2..8)
//  BURST_W         13    width of each master's burst-length field
//  TIMEOUT_CYCLES  255   idle cycles within a burst before forced release (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1                  system clock, rising edge
//  reset       in   1                  synchronous, active-high reset
//  req         in   N_MASTERS          per-master bus request, level
//  burst_len   in   N_MASTERS*BURST_W  per-master beat count minus 1; slice i = [i*BURST_W +: BURST_W]
//  beat_valid  in   1                  bus beat valid (from owning master)
//  beat_ready  in   1                  bus beat ready (from selected slave)
//  grant       out  N_MASTERS          one-hot grant, registered
//  grant_id    out  $clog2(N_MASTERS)  index of current owner; 0 when idle
//  busy        out  1                  high while any grant is asserted
//  burst_done  out  1                  1-cycle pulse: burst completed normally
//  abort       out  1                  1-cycle pulse: owner dropped req mid-burst
//  timeout     out  1                  1-cycle pulse: watchdog release (tied 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, grant_id=0, busy=0, all pulses 0, rr_ptr=0, beat_cnt=0, wd_cnt=0. Mid-burst reset drops grant next edge.
//  FSM IDLE -> XFER -> RELEASE -> IDLE.
//  IDLE: if |req, winner = first requester at or after rr_ptr (wrapping N_MASTERS-1 -> 0);
//    latch len = burst_len[winner]; beat_cnt=0; grant/grant_id/busy set at the same edge -> XFER.
//    Latency: req sampled high at edge t -> grant visible after edge t.
//  XFER: beat = beat_valid & beat_ready. On beat with beat_cnt==len -> RELEASE, burst_done=1; else beat_cnt++.
//    len=0 means single beat; max burst = 2^BURST_W beats; beat_cnt is BURST_W bits, never wraps.
//    Owner req low (no beat on the same cycle) -> RELEASE, abort=1. Beat and req drop on the same cycle: the beat counts;
//    if it was the last beat, burst_done only (no abort).
//    burst_len changes after grant are ignored (latched value is used).
//  RELEASE: grant=0, busy=0, grant_id=0; rr_ptr = owner+1 (wrapping). Next edge -> IDLE. Pulses last exactly this cycle.
//    Bus turnaround: last beat at edge k -> grant low after k, earliest new grant after edge k+2.
//  Only one grant bit ever high; no grant while in IDLE or RELEASE. Non-owner req changes never affect the current burst.
//  All outputs are registered; no combinational path from req/beat_* to grant.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: wd_cnt counts XFER cycles with no beat, clears on each beat; on wd_cnt==TIMEOUT_CYCLES-1 with no beat
//    -> RELEASE, timeout=1 (abort and burst_done stay 0); wd_cnt cleared on entering XFER.
//  ARB_TIMEOUT_EN undefined: no wd_cnt logic; timeout tied 0; a stalled owner holds the bus indefinitely.
// STRUCTURE
//  Package bus_pkg: arb_state_t enum {ARB_IDLE, ARB_XFER, ARB_RELEASE}; MAX_MASTERS=8 constant; shared with master/slave port blocks.
//  One sub-module rr_pick: combinational round-robin priority encoder (req, rr_ptr -> winner index, valid).
//  FSM, beat counter, watchdog and output registers in the top module.
// TESTING
//  1. N=2, req=2'b01, len0=3, beat every cycle -> grant=01 after 1 edge, 4 beats, burst_done pulse, grant low, busy low.
//  2. N=4, req=4'b1111 held, len=0 all -> grants 0001,0010,0100,1000,0001 in order, 3-cycle spacing each.
//  3. Owner 1 drops req after 2 of 5 beats -> abort pulse, no burst_done, next grant to master 2 if requesting.
//  4. Beat stalled: beat_ready=0 for 10 cycles mid-burst -> grant held, beat_cnt frozen, completes after stall.
//  5. reset asserted mid-XFER -> next edge grant=0, rr_ptr=0; after release, master 0 wins over master 1.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no beats after grant -> timeout pulse after 16 XFER cycles; undefined: grant stays high.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus-fabric definitions: arbiter state encoding and master-count limits.
// Imported by the arbiter and by the master/slave port blocks.
package bus_pkg;

   localparam int MAX_MASTERS = 8;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_XFER    = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

   // True when a master count is one the arbiter can be built for.
   function automatic bit n_masters_ok(input int n);
      return (n >= 2) && (n <= MAX_MASTERS);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: the first requester at or after
// rr_ptr, wrapping from N_MASTERS-1 back to 0.
module rr_pick #(
   parameter int N_MASTERS = 2,
   parameter int ID_W      = 1
) (
   input  logic [N_MASTERS-1:0] req,
   input  logic [ID_W-1:0]      rr_ptr,
   output logic [ID_W-1:0]      winner,
   output logic                 valid
);

   logic [ID_W:0] idx;

   // One extra bit on idx lets rr_ptr+i overflow before the wrap is subtracted.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
         if (idx >= (ID_W + 1)'(N_MASTERS)) begin
            idx = idx - (ID_W + 1)'(N_MASTERS);
         end
         if (!valid && req[idx[ID_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin bus arbiter holding ownership for a counted burst.
// Optional watchdog release is built when ARB_TIMEOUT_EN is defined.
module bus_arbiter_rr
   import bus_pkg::*;
#(
   parameter int N_MASTERS      = 2,
   parameter int BURST_W        = 13,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_MASTERS-1:0]         req,
   input  logic [N_MASTERS*BURST_W-1:0] burst_len,
   input  logic                         beat_valid,
   input  logic                         beat_ready,
   output logic [N_MASTERS-1:0]         grant,
   output logic [$clog2(N_MASTERS)-1:0] grant_id,
   output logic                         busy,
   output logic                         burst_done,
   output logic                         abort,
   output logic                         timeout
);

   localparam int ID_W = $clog2(N_MASTERS);

   arb_state_t         state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    winner;
   logic               win_valid;
   logic [ID_W-1:0]    next_ptr;
   logic [BURST_W-1:0] len;
   logic [BURST_W-1:0] beat_cnt;
   logic               beat;
   logic               end_done;
   logic               end_abort;
   logic               end_timeout;
   logic               end_burst;

`ifdef ARB_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] wd_cnt;
`endif

   rr_pick #(
      .N_MASTERS (N_MASTERS),
      .ID_W      (ID_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .valid  (win_valid)
   );

   assign beat     = beat_valid & beat_ready;
   assign next_ptr = (grant_id == ID_W'(N_MASTERS - 1)) ? '0 : grant_id + 1'b1;

   // A beat always wins over a req drop on the same cycle; the watchdog only fires on a beat-less cycle.
   always_comb begin
      end_done    = 1'b0;
      end_abort   = 1'b0;
      end_timeout = 1'b0;
      if (state == ARB_XFER) begin
         if (beat) begin
            end_done = (beat_cnt == len);
         end else if (!req[grant_id]) begin
            end_abort = 1'b1;
         end else begin
`ifdef ARB_TIMEOUT_EN
            end_timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
            end_timeout = 1'b0;
`endif
         end
      end
   end

   assign end_burst = end_done | end_abort | end_timeout;

`ifndef ARB_TIMEOUT_EN
   // Watchdog not built: the timeout parameter only shapes the port contract.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB_IDLE;
         grant      <= '0;
         grant_id   <= '0;
         busy       <= 1'b0;
         burst_done <= 1'b0;
         abort      <= 1'b0;
         rr_ptr     <= '0;
         len        <= '0;
         beat_cnt   <= '0;
`ifdef ARB_TIMEOUT_EN
         timeout    <= 1'b0;
         wd_cnt     <= '0;
`endif
      end else begin
         burst_done <= 1'b0;
         abort      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         timeout    <= 1'b0;
`endif
         case (state)
            ARB_IDLE: begin
               if (win_valid) begin
                  state    <= ARB_XFER;
                  grant    <= {{(N_MASTERS - 1){1'b0}}, 1'b1} << winner;
                  grant_id <= winner;
                  busy     <= 1'b1;
                  len      <= burst_len[winner * BURST_W +: BURST_W];
                  beat_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
                  wd_cnt   <= '0;
`endif
               end
            end

            ARB_XFER: begin
               if (end_burst) begin
                  state      <= ARB_RELEASE;
                  grant      <= '0;
                  grant_id   <= '0;
                  busy       <= 1'b0;
                  rr_ptr     <= next_ptr;
                  burst_done <= end_done;
                  abort      <= end_abort;
`ifdef ARB_TIMEOUT_EN
                  timeout    <= end_timeout;
`endif
               end else if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
`ifdef ARB_TIMEOUT_EN
               if (beat) begin
                  wd_cnt <= '0;
               end else if (!end_burst) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end

            ARB_RELEASE: begin
               state <= ARB_IDLE;
            end

            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomised self-checking bench for bus_arbiter_rr against a transaction-level owner model.
// Model includes the watchdog only when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter_rr;

   localparam int N  = 4;
   localparam int BW = 4;
   localparam int TO = 16;
   localparam int IW = $clog2(N);

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*BW-1:0] burst_len;
   logic            beat_valid;
   logic            beat_ready;
   logic [N-1:0]    grant;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            burst_done;
   logic            abort;
   logic            timeout;

   int checks = 0;
   int passed = 0;

   // Model: owner index (-1 = bus free), beats still owed, one-cycle cooldown, next priority, idle run.
   int owner     = -1;
   int remaining = 0;
   int cool      = 0;
   int ptr       = 0;
   int stall     = 0;
   logic [2:0] exp_pulse;

   bus_arbiter_rr #(
      .N_MASTERS      (N),
      .BURST_W        (BW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .burst_len  (burst_len),
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .grant      (grant),
      .grant_id   (grant_id),
      .busy       (busy),
      .burst_done (burst_done),
      .abort      (abort),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic releaseBus(input logic [2:0] pulse);
      exp_pulse = pulse;
      ptr       = (owner + 1) % N;
      owner     = -1;
      cool      = 1;
   endtask

   task automatic modelStep();
      exp_pulse = 3'b000;
      if (reset) begin
         owner = -1; remaining = 0; cool = 0; ptr = 0; stall = 0;
      end else if (owner >= 0) begin
         if (beat_valid && beat_ready) begin
            remaining--;
            stall = 0;
            if (remaining == 0) releaseBus(3'b100);
         end else if (!req[owner]) begin
            releaseBus(3'b010);
         end else begin
`ifdef ARB_TIMEOUT_EN
            stall++;
            if (stall == TO) releaseBus(3'b001);
`endif
         end
      end else if (cool > 0) begin
         cool = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (owner < 0 && req[k]) begin
               owner     = k;
               remaining = int'(burst_len[k*BW +: BW]) + 1;
               stall     = 0;
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic [N*BW-1:0] bl,
                                input logic v, input logic rd);
      logic [31:0] eg;
      @(negedge clk);
      reset = r; req = rq; burst_len = bl; beat_valid = v; beat_ready = rd;
      @(posedge clk);
      modelStep();
      #1;
      eg = (owner >= 0) ? (32'd1 << owner) : 32'd0;
      checkOutput("grant", 32'(grant), eg);
      checkOutput("grant_id", 32'(grant_id), (owner >= 0) ? 32'(owner) : 32'd0);
      checkOutput("busy", 32'(busy), (owner >= 0) ? 32'd1 : 32'd0);
      checkOutput("pulses", 32'({burst_done, abort, timeout}), 32'(exp_pulse));
   endtask

   initial begin
      logic [N-1:0]    rq;
      logic [N*BW-1:0] bl;
      reset = 1'b1; req = '0; burst_len = '0; beat_valid = 1'b0; beat_ready = 1'b0;

      repeat (2) applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);

      // Everyone requesting single-beat bursts: grants rotate 0,1,2,3,0 with 3-cycle spacing.
      repeat (16) applyStimulus(1'b0, 4'b1111, '0, 1'b1, 1'b1);

      // Long stall inside a 4-beat burst, then completion.
      bl = {4'd0, 4'd0, 4'd0, 4'd3};
      repeat (3) applyStimulus(1'b0, 4'b0001, bl, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0001, bl, 1'b1, 1'b1);
      repeat (20) applyStimulus(1'b0, 4'b0001, bl, 1'b1, 1'b0);
      repeat (6) applyStimulus(1'b0, 4'b0001, bl, 1'b1, 1'b1);

      // Owner drops req mid-burst while master 2 waits; then reset mid-burst.
      bl = {4'd0, 4'd2, 4'd4, 4'd7};
      repeat (4) applyStimulus(1'b0, 4'b0110, bl, 1'b1, 1'b1);
      repeat (6) applyStimulus(1'b0, 4'b0100, bl, 1'b1, 1'b1);
      repeat (3) applyStimulus(1'b0, 4'b0011, bl, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'b0011, bl, 1'b1, 1'b1);
      repeat (6) applyStimulus(1'b0, 4'b0011, bl, 1'b1, 1'b1);

      // Randomised traffic: slowly changing requests, random lengths and handshakes, rare resets.
      rq = 4'b1010;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
         end
         bl = N*BW'($urandom);
         applyStimulus($urandom_range(0, 99) == 0, rq, bl,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      end

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
